// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between a cache (256-bit lines) and a memory port (4 x 64-bit bursts).
// The adaptor takes the slave view; whoever drives the cache and memory sides takes the master view.
interface cacheline_adaptor_if;
    // Cache side
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    // Memory side
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line request into four 64-bit memory beats.
// A single line buffer serves both as the read assembly area and the write source.
module cacheline_adaptor (
    input  logic                 clk,
    input  logic                 rst,
    cacheline_adaptor_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [255:0]  line_q, line_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    beat_lsb;

    assign beat_lsb = {cnt_q, 6'd0};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        addr_d  = addr_q;

        unique case (state_q)
            IDLE: begin
                // Read wins when both requests arrive together.
                if (bus.read_i) begin
                    addr_d  = bus.address_i;
                    cnt_d   = 2'd0;
                    state_d = RD;
                end else if (bus.write_i) begin
                    addr_d  = bus.address_i;
                    line_d  = bus.line_i;
                    cnt_d   = 2'd0;
                    state_d = WR;
                end
            end
            RD: begin
                if (bus.resp_i) begin
                    line_d[beat_lsb +: 64] = bus.burst_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = DONE;
                end
            end
            WR: begin
                if (bus.resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            // NOTE: the line buffer is reset too, since line_o and burst_o must read zero in reset.
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
        end
    end

    // Outputs decode only registered state, so they are glitch-free across the edge.
    assign bus.read_o    = (state_q == RD);
    assign bus.write_o   = (state_q == WR);
    assign bus.resp_o    = (state_q == DONE);
    assign bus.address_o = {addr_q[31:5], 5'b0};
    assign bus.line_o    = line_q;
    assign bus.burst_o   = line_q[beat_lsb +: 64];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed plus randomized bench for cacheline_adaptor; expectations come from a line-level model.
module tb_cacheline_adaptor;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [255:0] model_line;

    cacheline_adaptor_if bus ();

    cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] rand256();
        return {rand64(), rand64(), rand64(), rand64()};
    endfunction

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return a & ~32'h1F;
    endfunction

    // Full line read; optionally keep read_i high past DONE, assert write_i too, or send a fifth beat in DONE.
    task automatic do_read(input logic [31:0] addr, input logic [63:0] beats [4],
                           input int min_gap, input int max_gap,
                           input bit hold, input bit both, input bit extra);
        logic [255:0] exp_line;
        exp_line = '0;
        for (int i = 0; i < 4; i++) exp_line = exp_line | (256'(beats[i]) << (64 * i));

        bus.read_i    = 1'b1;
        bus.write_i   = both;
        bus.address_i = addr;
        bus.line_i    = rand256();
        step();
        bus.read_i    = hold;
        bus.write_i   = 1'b0;
        bus.address_i = $urandom();
        bus.line_i    = rand256();
        check("rd_read_o", 256'(bus.read_o), 256'(1'b1));
        check("rd_write_o", 256'(bus.write_o), 256'(1'b0));
        check("rd_addr", 256'(bus.address_o), 256'(line_addr(addr)));

        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = $urandom_range(max_gap, min_gap);
            for (int g = 0; g < gap; g++) begin
                bus.resp_i  = 1'b0;
                bus.burst_i = rand64();
                step();
                check("rd_stall_read_o", 256'(bus.read_o), 256'(1'b1));
                check("rd_stall_resp_o", 256'(bus.resp_o), 256'(1'b0));
            end
            bus.resp_i  = 1'b1;
            bus.burst_i = beats[i];
            step();
            if (i < 3) check("rd_early_resp_o", 256'(bus.resp_o), 256'(1'b0));
        end

        bus.resp_i  = extra;
        bus.burst_i = rand64();
        check("rd_resp_o", 256'(bus.resp_o), 256'(1'b1));
        check("rd_done_read_o", 256'(bus.read_o), 256'(1'b0));
        check("rd_done_addr", 256'(bus.address_o), 256'(line_addr(addr)));
        check("rd_line", bus.line_o, exp_line);
        step();
        bus.resp_i = 1'b0;
        check("rd_resp_pulse", 256'(bus.resp_o), 256'(1'b0));
        check("rd_idle_read_o", 256'(bus.read_o), 256'(1'b0));
        check("rd_line_hold", bus.line_o, exp_line);
        model_line = exp_line;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int min_gap, input int max_gap);
        bus.write_i   = 1'b1;
        bus.read_i    = 1'b0;
        bus.address_i = addr;
        bus.line_i    = line;
        step();
        bus.write_i   = 1'b0;
        bus.address_i = $urandom();
        bus.line_i    = rand256();
        check("wr_write_o", 256'(bus.write_o), 256'(1'b1));
        check("wr_read_o", 256'(bus.read_o), 256'(1'b0));
        check("wr_addr", 256'(bus.address_o), 256'(line_addr(addr)));

        for (int i = 0; i < 4; i++) begin
            logic [63:0] exp_beat;
            int gap;
            exp_beat = 64'(line >> (64 * i));
            gap = $urandom_range(max_gap, min_gap);
            for (int g = 0; g < gap; g++) begin
                bus.resp_i = 1'b0;
                check("wr_gap_burst", 256'(bus.burst_o), 256'(exp_beat));
                step();
                check("wr_stall_write_o", 256'(bus.write_o), 256'(1'b1));
            end
            check("wr_burst", 256'(bus.burst_o), 256'(exp_beat));
            bus.resp_i = 1'b1;
            step();
            if (i < 3) check("wr_early_resp_o", 256'(bus.resp_o), 256'(1'b0));
        end

        bus.resp_i = 1'b0;
        check("wr_resp_o", 256'(bus.resp_o), 256'(1'b1));
        check("wr_done_write_o", 256'(bus.write_o), 256'(1'b0));
        step();
        check("wr_resp_pulse", 256'(bus.resp_o), 256'(1'b0));
        check("wr_line", bus.line_o, line);
        model_line = line;
    endtask

    task automatic stray_beats(input int n);
        for (int i = 0; i < n; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = rand64();
            step();
            check("stray_resp_o", 256'(bus.resp_o), 256'(1'b0));
            check("stray_line", bus.line_o, model_line);
            check("stray_read_o", 256'(bus.read_o), 256'(1'b0));
        end
        bus.resp_i = 1'b0;
    endtask

    initial begin
        logic [63:0] beats [4];
        checks     = 0;
        failures   = 0;
        model_line = '0;

        rst           = 1'b0;
        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        #3;
        check("rst_read_o", 256'(bus.read_o), 256'(1'b0));
        check("rst_write_o", 256'(bus.write_o), 256'(1'b0));
        check("rst_resp_o", 256'(bus.resp_o), 256'(1'b0));
        check("rst_addr", 256'(bus.address_o), 256'(32'h0));
        check("rst_line", bus.line_o, 256'h0);
        check("rst_burst", 256'(bus.burst_o), 256'(64'h0));
        step();
        rst = 1'b1;
        step();

        // Directed read, back-to-back beats
        beats[0] = {16{4'h1}};
        beats[1] = {16{4'h2}};
        beats[2] = {16{4'h3}};
        beats[3] = {16{4'h4}};
        do_read(32'h0000_1234, beats, 0, 0, 1'b0, 1'b0, 1'b0);

        // Directed write with 2-cycle gaps
        do_write(32'h8000_0040, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 2, 2);

        // Simultaneous request resolves as a read, plus a fifth beat presented in DONE
        for (int i = 0; i < 4; i++) beats[i] = rand64();
        do_read(32'h0000_0ABC, beats, 0, 1, 1'b0, 1'b1, 1'b1);

        // Stray beats while idle
        stray_beats(3);

        // Reset mid-read after two beats
        bus.read_i    = 1'b1;
        bus.address_i = 32'h0000_2000;
        step();
        bus.read_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = rand64();
            step();
        end
        bus.resp_i = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_read_o", 256'(bus.read_o), 256'(1'b0));
        check("abort_line", bus.line_o, 256'h0);
        check("abort_addr", 256'(bus.address_o), 256'(32'h0));
        check("abort_resp_o", 256'(bus.resp_o), 256'(1'b0));
        step();
        rst = 1'b1;
        model_line = '0;
        step();
        check("post_abort_idle", 256'(bus.read_o), 256'(1'b0));
        check("post_abort_resp", 256'(bus.resp_o), 256'(1'b0));
        for (int i = 0; i < 4; i++) beats[i] = rand64();
        do_read(32'h0000_3FFF, beats, 0, 0, 1'b0, 1'b0, 1'b0);

        // Back-to-back: request held through DONE starts a fresh read from beat 0
        for (int i = 0; i < 4; i++) beats[i] = rand64();
        do_read(32'h0000_4000, beats, 0, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) beats[i] = rand64();
        do_read(32'h0000_4020, beats, 0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized mix of reads and writes with random stalls and stray beats
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(1, 0) == 1) begin
                for (int i = 0; i < 4; i++) beats[i] = rand64();
                do_read($urandom(), beats, 0, 3, 1'b0, 1'($urandom_range(1, 0)),
                        1'($urandom_range(1, 0)));
            end else begin
                do_write($urandom(), rand256(), 0, 3);
            end
            stray_beats($urandom_range(2, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
